// File: rtl/uart_rx_frame.sv
// 8-bit UART receiver: 1 start, 8 data LSB first, 1 parity, 1 stop; rx_valid pulses at the stop-bit sample.
// Latency ~10.5 bit periods + 3 clk from the pin's falling edge; no backpressure, each frame is reported once.

package uart_rx_frame_pkg;
  typedef logic [7:0] data_t;
endpackage

module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_rx,
  output data_t o_rx_data,
  output logic  o_rx_valid,
  output logic  o_parity_err,
  output logic  o_frame_err,
  output logic  o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  data_t         r_shift;
  logic          r_par_err_pend;
  data_t         r_rx_data;
  logic          r_rx_valid;
  logic          r_parity_err;
  logic          r_frame_err;
  logic          r_busy;

  logic w_rx_s;
  logic w_mid;
  logic w_bit_end;

  assign w_rx_s    = r_sync2;
  assign w_mid     = (r_cnt == CNT_MID);
  assign w_bit_end = (r_cnt == CNT_LAST);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_shift        <= '0;
      r_par_err_pend <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_parity_err   <= 1'b0;
      r_frame_err    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_mid) begin
            r_cnt <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_par_err_pend <= ((^r_shift) ^ w_rx_s) != PARITY_ODD;
            r_state        <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt        <= '0;
            r_rx_data    <= r_shift;
            r_parity_err <= r_par_err_pend;
            r_frame_err  <= ~w_rx_s;
            r_rx_valid   <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: even and odd parity instances, scoreboard queues checked by negedge monitors.
module tb_uart_rx_frame;

  localparam int CPB     = 16;
  localparam int LAT_EXP = 171;  // 10.5*CPB + 3 cycles from pin fall to rx_valid

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_e = 1'b1;
  logic       rx_o = 1'b1;
  logic [7:0] data_e, data_o;
  logic       vld_e, vld_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pulses_e = 0;
  int   pulses_o = 0;
  exp_t q_e[$];
  exp_t q_o[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_e (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_e),
    .o_rx_data(data_e), .o_rx_valid(vld_e), .o_parity_err(pe_e),
    .o_frame_err(fe_e), .o_busy(busy_e)
  );

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_o (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_o),
    .o_rx_data(data_o), .o_rx_valid(vld_o), .o_parity_err(pe_o),
    .o_frame_err(fe_o), .o_busy(busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one frame; parity bit follows mode, optionally inverted; stop level given.
  task automatic send_frame(input logic [7:0] d, input bit odd_line, input bit flip,
                            input logic stop, input bit expect_pulse);
    logic        p;
    logic [10:0] fr;
    exp_t        e;
    p  = (odd_line ? ~(^d) : (^d)) ^ flip;
    fr = {stop, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      if (odd_line) rx_o = fr[i];
      else          rx_e = fr[i];
      if (i == 0 && expect_pulse) begin
        e.d  = d;
        e.pe = flip;
        e.fe = ~stop;
        e.st = cyc;
        if (odd_line) q_o.push_back(e);
        else          q_e.push_back(e);
      end
      repeat (CPB - 1) @(posedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vld_e) begin
      pulses_e++;
      if (q_e.size() == 0) begin
        chk("unexpected_pulse_even", 32'(data_e), 32'hFFFF_FFFF);
      end else begin
        e = q_e.pop_front();
        chk("even_data", 32'(data_e), 32'(e.d));
        chk("even_parity_err", 32'(pe_e), 32'(e.pe));
        chk("even_frame_err", 32'(fe_e), 32'(e.fe));
        chk("even_busy_at_valid", 32'(busy_e), 32'd0);
        n_checks++;
        if ((cyc - e.st) < LAT_EXP - 4 || (cyc - e.st) > LAT_EXP + 4) begin
          n_errors++;
          $display("FAIL even_latency: got %0d cycles expected %0d +/-4", cyc - e.st, LAT_EXP);
        end
      end
    end
    if (vld_o) begin
      pulses_o++;
      if (q_o.size() == 0) begin
        chk("unexpected_pulse_odd", 32'(data_o), 32'hFFFF_FFFF);
      end else begin
        e = q_o.pop_front();
        chk("odd_data", 32'(data_o), 32'(e.d));
        chk("odd_parity_err", 32'(pe_o), 32'(e.pe));
        chk("odd_frame_err", 32'(fe_o), 32'(e.fe));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("reset_data", 32'(data_e), 32'h00);
    chk("reset_valid", 32'(vld_e), 32'd0);
    chk("reset_parity_err", 32'(pe_e), 32'd0);
    chk("reset_frame_err", 32'(fe_e), 32'd0);
    chk("reset_busy", 32'(busy_e), 32'd0);
    chk("reset_busy_odd", 32'(busy_o), 32'd0);
    idle_cycles(4);

    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(CPB);
    send_frame(8'hA7, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_cycles(CPB);
    send_frame(8'hA7, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_cycles(CPB);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rx_e = 1'b1;
    idle_cycles(2 * CPB);
    chk("busy_after_frame_err", 32'(busy_e), 32'd0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(CPB);

    // Glitch: low for a quarter bit only.
    @(posedge clk);
    #1 rx_e = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1 rx_e = 1'b1;
    idle_cycles(2 * CPB);
    chk("busy_after_glitch", 32'(busy_e), 32'd0);

    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(CPB);
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_cycles(CPB);
    chk("pre_reset_data", 32'(data_e), 32'h96);

    // 0xF1 keeps the line high from bit 4 on, so the aborted tail cannot look like a start bit.
    fork
      send_frame(8'hF1, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (91) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("midframe_reset_data", 32'(data_e), 32'h00);
        chk("midframe_reset_valid", 32'(vld_e), 32'd0);
        chk("midframe_reset_parity_err", 32'(pe_e), 32'd0);
        chk("midframe_reset_frame_err", 32'(fe_e), 32'd0);
        chk("midframe_reset_busy", 32'(busy_e), 32'd0);
      end
    join
    idle_cycles(CPB);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(2 * CPB);

    chk("even_pulse_count", 32'(pulses_e), 32'd8);
    chk("odd_pulse_count", 32'(pulses_o), 32'd1);
    chk("even_queue_drained", 32'(q_e.size()), 32'd0);
    chk("odd_queue_drained", 32'(q_o.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receiver for the 8-bit UART link: oversamples the `rx` line, recovers 1 start + 8 data (LSB first) + 1 parity + 1 stop frames, and presents the byte with parity and framing status. It is the receive half of the `top` UART loopback and pairs bit-for-bit with the transmitter's frame format. One clock domain; the asynchronous `rx` pin is synchronised internally.

## Interface
- `CLKS_PER_BIT`, 868: `clk` cycles per bit period; legal range ≥ 4. Counter width is $clog2(CLKS_PER_BIT).
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high; takes effect on the rising edge of `clk` while high.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8 (`data_t`)  last received byte; holds its value until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when a frame completes, good or bad.
- `parity_err`  out  1  parity status of the last frame; valid with and after `rx_valid`.
- `frame_err`  out  1  stop bit sampled low in the last frame; valid with and after `rx_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchroniser: two flops on `rx` produce `rx_s`. Flops reset to 1. All logic below uses `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP. Bit counter 0..CLKS_PER_BIT-1 and data index 0..7.
- IDLE: counter cleared. On `rx_s`=0, go to START with counter=0.
- START: when counter reaches (CLKS_PER_BIT-1)/2 (mid-bit), sample `rx_s`.
  - 1: glitch. Return to IDLE and do not pulse `rx_valid`.
  - 0: clear the counter and go to DATA with index 0.
- DATA: each time the counter reaches CLKS_PER_BIT-1, sample `rx_s` into shift bit [index] (LSB first) and clear the counter.
  - After index 7 is sampled, go to PARITY.
- PARITY: at the full bit period, sample the parity bit `p`.
  - Even mode: error = ^data ^ p ≠ 0.
  - Odd mode: error = ^data ^ p ≠ 1.
  - Then go to STOP.
- STOP: at the full bit period, sample the stop bit and go to IDLE. On that same edge:
  - Load `rx_data` from the shift register.
  - Load `parity_err` and `frame_err` (frame_err = stop sample is 0).
  - Assert `rx_valid`.
- Framing errors still deliver the byte with `frame_err`=1.
- Break or line held low: after STOP the FSM returns to IDLE. If `rx_s` is still 0, it restarts START immediately. No lock-up.
- Reset mid-frame: on the `rst` edge the FSM returns to IDLE and the partial frame is discarded. No `rx_valid` pulse is produced.
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - FSM in IDLE, counters 0, synchroniser flops 1.

## Timing
- Define edge E as the `clk` edge on which `rx_s` is first seen low in IDLE. This is 2 cycles after the `rx` pin falls.
- Start sample: at E + 1 + (CLKS_PER_BIT-1)/2.
- Data bit k sample: one full CLKS_PER_BIT after the previous sample. This keeps every sample near mid-bit.
- `rx_valid` edge: rises on the stop-bit sample edge, which is 10 bit periods after the start sample. It is high for exactly one cycle.
- Frame latency: pin falling edge to `rx_valid` ≈ 10.5 bit periods + 3 cycles.
- `busy`: rises the cycle after E. It falls on the same edge that `rx_valid` rises.
- Back-to-back frames: a start bit that begins immediately after the stop bit is accepted with no idle gap required. The next IDLE→START transition can occur on the cycle after `rx_valid`.
- Output stability: `rx_data`, `parity_err` and `frame_err` change only on the `rx_valid` edge or on reset.

## Test plan
- Loopback with `top`:
  - Stimulus: transmitter sends 8'h55, even parity, CLKS_PER_BIT=868.
  - Response: one `rx_valid` pulse, `rx_data`=8'h55, `parity_err`=0, `frame_err`=0.
  - Pulse arrives within 10.5 bit periods ±4 cycles of the start edge.
- Parity:
  - Stimulus: bench drives 8'hA7 with the parity bit inverted, even mode.
  - Response: `rx_data`=8'hA7, `parity_err`=1.
  - Stimulus: same frame repeated in odd mode with the correct parity bit.
  - Response: `parity_err`=0.
- Framing:
  - Stimulus: 8'h3C with the stop bit driven 0, then the line returned high.
  - Response: `rx_data`=8'h3C, `frame_err`=1, `busy` drops, and the next good frame 8'h01 is received cleanly.
- Glitch rejection:
  - Stimulus: `rx` low for CLKS_PER_BIT/4 cycles, then high.
  - Response: FSM returns to IDLE and there is no `rx_valid` pulse.
- Back-to-back plus reset:
  - Stimulus: two frames 8'hFF and 8'h00 with zero idle gap.
  - Response: two pulses with the correct bytes.
  - Stimulus: a third frame with `rst` asserted for 1 cycle at the bit-4 mid-sample.
  - Response: no pulse for the third frame, all outputs at reset values, and a subsequent frame 8'h81 is received correctly.
